// File: rtl/pe_sequencer.sv
// rtl/pe_sequencer.sv - walks center/out-channel/in-tile loops, issues buffer reads, drives PE control
module pe_sequencer #(
  parameter int CENTER_W  = 16,
  parameter int OUT_CH_W  = 6,
  parameter int IN_TILE_W = 8,
  parameter int ADDR_W    = 12,
  parameter int BUF_LAT   = 1,
  parameter int PE_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CENTER_W-1:0]  cfg_num_center,
  input  logic [OUT_CH_W-1:0]  cfg_num_out_ch,
  input  logic [IN_TILE_W-1:0] cfg_num_in_tile,
  input  logic                 cfg_acc_omem,
  input  logic                 buf_stall,
  output logic                 buf_rd_en,
  output logic [ADDR_W-1:0]    ifm_addr,
  output logic [ADDR_W-1:0]    wgt_addr,
  output logic                 pe_in_valid,
  output logic [OUT_CH_W-1:0]  pe_out_ch,
  output logic                 pe_in_ch_end,
  output logic                 pe_new_center_in,
  output logic                 pe_psum_req,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // One beat of PE control travelling alongside the buffer read latency
  typedef struct packed {
    logic                v;
    logic [OUT_CH_W-1:0] o;
    logic                e;
    logic                n;
  } beat_t;

  localparam int                   DRAIN_N    = BUF_LAT + PE_LAT;
  localparam logic [7:0]           DRAIN_LAST = 8'(DRAIN_N - 1);
  localparam logic [CENTER_W-1:0]  C_ONE      = CENTER_W'(1);
  localparam logic [OUT_CH_W-1:0]  O_ONE      = OUT_CH_W'(1);
  localparam logic [IN_TILE_W-1:0] T_ONE      = IN_TILE_W'(1);

  state_t               state, state_nx;
  logic [CENTER_W-1:0]  n_c, ctr_c;
  logic [OUT_CH_W-1:0]  n_o, ctr_o;
  logic [IN_TILE_W-1:0] n_t, ctr_t;
  logic                 acc_omem_q;
  logic [ADDR_W-1:0]    ifm_base, wgt_base, nt_step;
  logic [7:0]           drain_cnt;
  beat_t                pipe [BUF_LAT];
  beat_t                stage_in;
  logic                 accept, cfg_zero, rd_en;
  logic                 t_last, o_last, c_last, last_beat;

  assign accept    = cfg_valid && (state == S_IDLE);
  assign cfg_zero  = (cfg_num_center == '0) || (cfg_num_out_ch == '0) || (cfg_num_in_tile == '0);
  assign rd_en     = (state == S_RUN) && !buf_stall;
  assign t_last    = (ctr_t == n_t - T_ONE);
  assign o_last    = (ctr_o == n_o - O_ONE);
  assign c_last    = (ctr_c == n_c - C_ONE);
  assign last_beat = t_last && o_last && c_last;
  assign nt_step   = ADDR_W'(n_t);

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign buf_rd_en = rd_en;
  // Bases hold c*N_T and o*N_T so the address is a single add of the tile index
  assign ifm_addr  = ifm_base + ADDR_W'(ctr_t);
  assign wgt_addr  = wgt_base + ADDR_W'(ctr_t);

  assign pe_in_valid      = pipe[BUF_LAT-1].v;
  assign pe_out_ch        = pipe[BUF_LAT-1].o;
  assign pe_in_ch_end     = pipe[BUF_LAT-1].e;
  assign pe_new_center_in = pipe[BUF_LAT-1].n;
  assign pe_psum_req      = pipe[BUF_LAT-1].e & acc_omem_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state: empty jobs skip straight to the done pulse
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = cfg_zero ? S_DONE : S_RUN;
      S_RUN:   if (rd_en && last_beat) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Drain timer covers the buffer latency plus the PE pipeline depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   drain_cnt <= '0;
    else if (state == S_DRAIN) drain_cnt <= drain_cnt + 8'd1;
    else                       drain_cnt <= '0;
  end

  // Job descriptor latched on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_c        <= '0;
      n_o        <= '0;
      n_t        <= '0;
      acc_omem_q <= 1'b0;
    end else if (accept) begin
      n_c        <= cfg_num_center;
      n_o        <= cfg_num_out_ch;
      n_t        <= cfg_num_in_tile;
      acc_omem_q <= cfg_acc_omem;
    end
  end

  // Loop counters and address bases; tile innermost, center outermost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_c    <= '0;
      ctr_o    <= '0;
      ctr_t    <= '0;
      ifm_base <= '0;
      wgt_base <= '0;
    end else if (accept) begin
      ctr_c    <= '0;
      ctr_o    <= '0;
      ctr_t    <= '0;
      ifm_base <= '0;
      wgt_base <= '0;
    end else if (rd_en) begin
      if (t_last) begin
        ctr_t <= '0;
        if (o_last) begin
          ctr_o    <= '0;
          wgt_base <= '0;
          if (c_last) begin
            ctr_c    <= '0;
            ifm_base <= '0;
          end else begin
            ctr_c    <= ctr_c + C_ONE;
            ifm_base <= ifm_base + nt_step;
          end
        end else begin
          ctr_o    <= ctr_o + O_ONE;
          wgt_base <= wgt_base + nt_step;
        end
      end else begin
        ctr_t <= ctr_t + T_ONE;
      end
    end
  end

  // Control fields are zeroed on idle beats so the PE sees clean flags
  always_comb begin
    stage_in   = '0;
    stage_in.v = rd_en;
    stage_in.o = rd_en ? ctr_o : '0;
    stage_in.e = rd_en && t_last;
    stage_in.n = rd_en && (ctr_t == '0);
  end

  // Delay line aligning PE control with returned buffer data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i < BUF_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// tb/tb_pe_sequencer.sv - randomized and directed bench for pe_sequencer with cycle-indexed model
module tb_pe_sequencer;

  localparam int CW = 16, OW = 6, TW = 8, AW = 12, BL = 1, PL = 4;
  localparam int BUDGET = 20000;

  logic          clk, rst, cfg_valid, cfg_ready, cfg_acc_omem, buf_stall, buf_rd_en;
  logic [CW-1:0] cfg_num_center;
  logic [OW-1:0] cfg_num_out_ch, pe_out_ch;
  logic [TW-1:0] cfg_num_in_tile;
  logic [AW-1:0] ifm_addr, wgt_addr;
  logic          pe_in_valid, pe_in_ch_end, pe_new_center_in, pe_psum_req, busy, done;

  pe_sequencer #(.CENTER_W(CW), .OUT_CH_W(OW), .IN_TILE_W(TW), .ADDR_W(AW),
                 .BUF_LAT(BL), .PE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_center(cfg_num_center), .cfg_num_out_ch(cfg_num_out_ch),
    .cfg_num_in_tile(cfg_num_in_tile), .cfg_acc_omem(cfg_acc_omem),
    .buf_stall(buf_stall), .buf_rd_en(buf_rd_en), .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
    .pe_in_valid(pe_in_valid), .pe_out_ch(pe_out_ch), .pe_in_ch_end(pe_in_ch_end),
    .pe_new_center_in(pe_new_center_in), .pe_psum_req(pe_psum_req), .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ifm;
    int wgt;
    int o;
    bit e;
    bit n;
  } mbeat_t;

  int checks = 0;
  int errors = 0;

  // Model: the job's full beat list, and what was issued on which cycle
  mbeat_t beats[$];
  mbeat_t issued[int];
  bit     m_act = 0;
  bit     m_acc = 0;
  int     done_cyc = -1;
  int     cyc = 0;

  // Observations used by the literal expectations
  int obs_ifm[$], obs_wgt[$];
  int pe_cnt, new_cnt, end_cnt, psum_cnt, first_rd, first_pe, acc_cyc, done_obs;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      beats.delete();
      issued.delete();
      m_act = 0;
      done_cyc = -1;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", buf_rd_en, 0);
      chk("rst_pe_valid", pe_in_valid, 0);
      chk("rst_ifm_addr", ifm_addr, 0);
      chk("rst_wgt_addr", wgt_addr, 0);
    end else begin
      bit     act0, exp_rd;
      mbeat_t b;
      act0   = m_act;
      exp_rd = m_act && (beats.size() > 0) && !buf_stall;
      chk("cfg_ready", cfg_ready, !m_act);
      chk("busy", busy, m_act);
      chk("done", done, m_act && (cyc == done_cyc));
      chk("buf_rd_en", buf_rd_en, exp_rd);
      if (exp_rd) begin
        b = beats.pop_front();
        chk("ifm_addr", ifm_addr, b.ifm);
        chk("wgt_addr", wgt_addr, b.wgt);
        issued[cyc] = b;
        if (beats.size() == 0) done_cyc = cyc + BL + PL + 1;
      end
      if (issued.exists(cyc - BL)) begin
        b = issued[cyc - BL];
        chk("pe_in_valid", pe_in_valid, 1);
        chk("pe_out_ch", pe_out_ch, b.o);
        chk("pe_in_ch_end", pe_in_ch_end, b.e);
        chk("pe_new_center_in", pe_new_center_in, b.n);
        chk("pe_psum_req", pe_psum_req, b.e && m_acc);
      end else begin
        chk("pe_idle", {pe_in_valid, pe_out_ch, pe_in_ch_end, pe_new_center_in, pe_psum_req}, 0);
      end
      // observations
      if (cfg_valid && cfg_ready) acc_cyc = cyc;
      if (done) done_obs = cyc;
      if (buf_rd_en) begin
        if (obs_ifm.size() == 0) first_rd = cyc;
        obs_ifm.push_back(int'(ifm_addr));
        obs_wgt.push_back(int'(wgt_addr));
      end
      if (pe_in_valid) begin
        if (pe_cnt == 0) first_pe = cyc;
        pe_cnt++;
        new_cnt  += int'(pe_new_center_in);
        end_cnt  += int'(pe_in_ch_end);
        psum_cnt += int'(pe_psum_req);
      end
      // model advance
      if (act0 && cyc == done_cyc) begin
        m_act = 0;
        issued.delete();
      end else if (!act0 && cfg_valid) begin
        int nc, no, nt;
        nc = int'(cfg_num_center);
        no = int'(cfg_num_out_ch);
        nt = int'(cfg_num_in_tile);
        m_act = 1;
        m_acc = cfg_acc_omem;
        beats.delete();
        for (int c = 0; c < nc; c++)
          for (int o = 0; o < no; o++)
            for (int t = 0; t < nt; t++) begin
              b.ifm = (c * nt + t) % (1 << AW);
              b.wgt = (o * nt + t) % (1 << AW);
              b.o = o;
              b.e = (t == nt - 1);
              b.n = (t == 0);
              beats.push_back(b);
            end
        done_cyc = (beats.size() == 0) ? cyc + 1 : -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_ifm.delete();
    obs_wgt.delete();
    pe_cnt = 0; new_cnt = 0; end_cnt = 0; psum_cnt = 0;
    first_rd = -1; first_pe = -1; acc_cyc = -1; done_obs = -1;
  endtask

  // smode: 0 no stall, 1 stall cycles 5,6,8,9 after accept, 2 random; vmode: noise cfg_valid while busy
  task automatic run_job(input int nc, input int no, input int nt, input bit acc,
                         input int smode, input bit vmode);
    int k;
    clear_obs();
    cfg_num_center  = CW'(nc);
    cfg_num_out_ch  = OW'(no);
    cfg_num_in_tile = TW'(nt);
    cfg_acc_omem    = acc;
    cfg_valid       = 1'b1;
    step();
    cfg_valid = 1'b0;
    k = 1;
    while (m_act && k < BUDGET) begin
      case (smode)
        1:       buf_stall = (k == 5 || k == 6 || k == 8 || k == 9);
        2:       buf_stall = ($urandom_range(0, 3) == 0);
        default: buf_stall = 1'b0;
      endcase
      if (vmode) begin
        cfg_valid       = m_act && ($urandom_range(0, 2) == 0);
        cfg_num_center  = CW'($urandom_range(0, 3));
        cfg_num_out_ch  = OW'($urandom_range(0, 3));
        cfg_num_in_tile = TW'($urandom_range(0, 3));
        cfg_acc_omem    = 1'($urandom_range(0, 1));
      end
      step();
      k++;
    end
    buf_stall = 1'b0;
    cfg_valid = 1'b0;
    if (k >= BUDGET) chk("job_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_num_center = '0;
    cfg_num_out_ch = '0;
    cfg_num_in_tile = '0;
    cfg_acc_omem = 1'b0;
    buf_stall = 1'b0;
    repeat (3) step();
    chk("reset_ready", cfg_ready, 1);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    step();

    // 1x1x1: rd one cycle after accept, PE beat next, done seven cycles after accept
    run_job(1, 1, 1, 0, 0, 0);
    chk("t1_rd_lat", first_rd - acc_cyc, 1);
    chk("t1_pe_lat", first_pe - first_rd, 1);
    chk("t1_done_lat", done_obs - acc_cyc, 7);
    chk("t1_beats", obs_ifm.size(), 1);
    chk("t1_new_end", new_cnt * 2 + end_cnt, 3);

    // 2x3x4 back-to-back
    run_job(2, 3, 4, 0, 0, 0);
    chk("t2_beats", obs_ifm.size(), 24);
    chk("t2_ifm5", obs_ifm[5], 1);
    chk("t2_wgt5", obs_wgt[5], 5);
    chk("t2_ifm12", obs_ifm[12], 4);
    chk("t2_wgt12", obs_wgt[12], 0);
    chk("t2_ifm23", obs_ifm[23], 7);
    chk("t2_wgt23", obs_wgt[23], 11);
    chk("t2_new", new_cnt, 6);
    chk("t2_end", end_cnt, 6);
    chk("t2_done_lat", done_obs - acc_cyc, 30);

    // same job with stalls
    run_job(2, 3, 4, 0, 1, 0);
    chk("t3_beats", obs_ifm.size(), 24);
    chk("t3_ifm23", obs_ifm[23], 7);
    chk("t3_wgt13", obs_wgt[13], 1);
    chk("t3_done_lat", done_obs - acc_cyc, 34);

    // empty job
    run_job(3, 0, 2, 0, 0, 0);
    chk("t4_beats", obs_ifm.size(), 0);
    chk("t4_done_lat", done_obs - acc_cyc, 1);

    // psum request on/off
    run_job(1, 2, 2, 1, 0, 0);
    chk("t5_psum", psum_cnt, 2);
    run_job(1, 2, 2, 0, 0, 0);
    chk("t5_nopsum", psum_cnt, 0);

    // reset in the middle of a job
    clear_obs();
    cfg_num_center = CW'(2); cfg_num_out_ch = OW'(3); cfg_num_in_tile = TW'(4);
    cfg_acc_omem = 1'b0;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 50 && obs_ifm.size() < 10; i++) step();
    chk("t6_reached10", obs_ifm.size(), 10);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", cfg_ready, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rd", buf_rd_en, 0);
    step();
    rst = 1'b0;
    step();
    run_job(2, 3, 4, 0, 0, 0);
    chk("t6_beats", obs_ifm.size(), 24);
    chk("t6_ifm0", obs_ifm[0], 0);
    chk("t6_wgt0", obs_wgt[0], 0);

    // address wrap
    run_job(17, 1, 255, 0, 0, 0);
    chk("t7_ifm_wrap", obs_ifm[obs_ifm.size() - 1], 238);
    run_job(2, 20, 255, 0, 0, 0);
    chk("t7_wgt_wrap", obs_wgt[obs_wgt.size() - 1], 1003);

    // randomized jobs with stalls and ignored descriptors while busy
    for (int j = 0; j < 30; j++) begin
      int nc, no, nt;
      nc = $urandom_range(0, 3);
      no = $urandom_range(0, 4);
      nt = $urandom_range(0, 5);
      run_job(nc, no, nt, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
      chk("rand_beats", obs_ifm.size(), nc * no * nt);
      chk("rand_pe", pe_cnt, nc * no * nt);
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
